// File: rtl/heater_sched_pkg.sv
// Shared types for the two-heater power scheduler: FSM state encoding,
// heater index constants and the grant-selection helper.
package heater_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ON_EXT = 2'd1,
        ST_ON_BED = 2'd2,
        ST_GAP    = 2'd3
    } state_e;

    localparam int HTR_EXT = 0;
    localparam int HTR_BED = 1;

    // Choose the next ON state from the effective requests; on a tie the
    // heater holding priority wins.
    function automatic state_e pick_grant(input logic [1:0] eff, input logic prio_bed);
        state_e st;
        st = ST_IDLE;
        if (eff[HTR_EXT] && eff[HTR_BED]) begin
            st = prio_bed ? ST_ON_BED : ST_ON_EXT;
        end else if (eff[HTR_EXT]) begin
            st = ST_ON_EXT;
        end else if (eff[HTR_BED]) begin
            st = ST_ON_BED;
        end
        return st;
    endfunction

endpackage

// File: rtl/runaway_timer.sv
// Per-heater runaway watchdog: counts consecutive request cycles and latches
// a fault when the limit is reached; a clear pulse releases it.
module runaway_timer
    import heater_sched_pkg::*;
#(
    parameter int RUNAWAY_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic clr_i,
    output logic fault_o
);

    localparam logic [31:0] LIMIT    = 32'(RUNAWAY_CYCLES);
    localparam logic [31:0] LIMIT_M1 = 32'(RUNAWAY_CYCLES - 1);

    logic [31:0] cnt_q, cnt_d;
    logic        fault_q, fault_d;
    logic        set_w;

    // Fault fires only on the cycle the count reaches the limit, so a
    // saturated counter never re-asserts it against a later clear.
    assign set_w = req_i && (cnt_q == LIMIT_M1);

    always_comb begin
        cnt_d   = cnt_q;
        fault_d = fault_q;
        if (clr_i || !req_i) begin
            cnt_d = 32'd0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 32'd1;
        end
        if (set_w) begin
            fault_d = 1'b1;
        end else if (clr_i) begin
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign fault_o = fault_q;

endmodule

// File: rtl/heater_scheduler.sv
// Time-slices a single heater power budget between extruder and bed:
// one heater on at a time, dead time between grants, runaway fault lockout.
module heater_scheduler
    import heater_sched_pkg::*;
#(
    parameter int SLICE_CYCLES   = 1000,
    parameter int GAP_CYCLES     = 100,
    parameter int RUNAWAY_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_ext,
    input  logic       req_bed,
    input  logic [1:0] clr_fault,
    output logic       heat_ext,
    output logic       heat_bed,
    output logic [1:0] fault,
    output logic       busy,
    output logic [1:0] dbg_state
);

    localparam int SW = $clog2(SLICE_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [SW-1:0] SLICE_LAST = SW'(SLICE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

    state_e        state_q, state_d;
    state_e        grant_w;
    logic [SW-1:0] slice_q, slice_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          prio_bed_q, prio_bed_d;
    logic          armed_q;
    logic          heat_ext_q, heat_bed_q;
    logic [1:0]    fault_w;
    logic [1:0]    eff_w;

    runaway_timer #(.RUNAWAY_CYCLES(RUNAWAY_CYCLES)) u_rt_ext (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req_ext),
        .clr_i   (clr_fault[HTR_EXT]),
        .fault_o (fault_w[HTR_EXT])
    );

    runaway_timer #(.RUNAWAY_CYCLES(RUNAWAY_CYCLES)) u_rt_bed (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req_bed),
        .clr_i   (clr_fault[HTR_BED]),
        .fault_o (fault_w[HTR_BED])
    );

    assign eff_w = {req_bed, req_ext} & ~fault_w;

    // armed_q holds off the first grant until one edge after reset release.
    assign grant_w = armed_q ? pick_grant(eff_w, prio_bed_q) : ST_IDLE;

    always_comb begin
        state_d    = state_q;
        slice_d    = slice_q;
        gap_d      = gap_q;
        prio_bed_d = prio_bed_q;
        case (state_q)
            ST_IDLE: begin
                state_d = grant_w;
            end
            ST_ON_EXT: begin
                if (!eff_w[HTR_EXT] || (slice_q == SLICE_LAST && eff_w[HTR_BED])) begin
                    state_d = ST_GAP;
                end else if (slice_q != SLICE_LAST) begin
                    slice_d = slice_q + 1'b1;
                end
            end
            ST_ON_BED: begin
                if (!eff_w[HTR_BED] || (slice_q == SLICE_LAST && eff_w[HTR_EXT])) begin
                    state_d = ST_GAP;
                end else if (slice_q != SLICE_LAST) begin
                    slice_d = slice_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = grant_w;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Counters restart on every state change; priority flips on each grant.
        if (state_d != state_q) begin
            slice_d = '0;
            gap_d   = '0;
            if (state_d == ST_ON_EXT) begin
                prio_bed_d = 1'b1;
            end else if (state_d == ST_ON_BED) begin
                prio_bed_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            slice_q    <= '0;
            gap_q      <= '0;
            prio_bed_q <= 1'b0;
            armed_q    <= 1'b0;
            heat_ext_q <= 1'b0;
            heat_bed_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slice_q    <= slice_d;
            gap_q      <= gap_d;
            prio_bed_q <= prio_bed_d;
            armed_q    <= 1'b1;
            heat_ext_q <= (state_d == ST_ON_EXT);
            heat_bed_q <= (state_d == ST_ON_BED);
        end
    end

    assign heat_ext  = heat_ext_q;
    assign heat_bed  = heat_bed_q;
    assign fault     = fault_w;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule
